// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and parameter defaults for the pipeline stall controller
//
// Purpose: FSM state encoding and default sizing for pipeline_stall_ctrl.
// Ports:   none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } state_e;

  localparam int MD_LAT_DEF = 8;   // max mul/div latency, also the watchdog limit
  localparam int CNT_W_DEF  = 4;   // mul/div cycle counter width
  localparam int PERF_W_DEF = 16;  // stall-cycle performance counter width

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose: counts cycles with inc high, holding at all-ones instead of wrapping.
// Ports:
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-high reset, clears the count
//   inc    in   increment request for this cycle
//   count  out  current count (WIDTH bits)
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - prioritised stall/flush sequencer with mul/div hold
//
// Purpose: merges branch, load-use and mul/div stall/flush sources into one
// control set for PC, IF_ID, ID_EX and EX_MEM; holds the pipeline during a
// multi-cycle mul/div, aborts it on a taken branch, and runs a watchdog.
// Ports:
//   clk_i, rst_i                     clock / async active-high reset
//   ld_use_i, branch_taken_i         hazard inputs (branch has top priority)
//   md_req_i, md_done_i              mul/div request in ID / unit result pulse
//   md_start_o, md_abort_o           one-cycle pulses to the mul/div unit
//   md_busy_o                        FSM is waiting on the mul/div unit
//   pc_write_o, if_id_write_o        load enables
//   if_flush_o, id_flush_o, ex_flush_o  control-field zeroing per stage
//   timeout_o                        sticky watchdog flag
//   stall_cnt_o                      saturating count of stalled cycles
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_use_i,
  input  logic              branch_taken_i,
  input  logic              md_req_i,
  input  logic              md_done_i,
  output logic              md_start_o,
  output logic              md_abort_o,
  output logic              md_busy_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_flush_o,
  output logic              id_flush_o,
  output logic              ex_flush_o,
  output logic              timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        // A load-use stall defers the mul/div start; the branch kills it.
        if (!branch_taken_i && !ld_use_i && md_req_i) begin
          state_d = ST_MD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_MD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Branch beats a same-cycle done: the result is wrong-path.
        if (branch_taken_i) begin
          state_d = ST_IDLE;
        end else if (md_done_i) begin
          state_d = ST_MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_MD_DONE;
        end
      end
      ST_MD_DONE: begin
        // md_req_i is still high for the advancing op; do not restart it.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic; everything is held at its idle value while rst_i is high,
  // independent of what the hazard inputs are doing.
  always_comb begin
    md_start_o    = 1'b0;
    md_abort_o    = 1'b0;
    md_busy_o     = 1'b0;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_flush_o    = 1'b0;
    id_flush_o    = 1'b0;
    ex_flush_o    = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (branch_taken_i) begin
            if_flush_o = 1'b1;
            id_flush_o = 1'b1;
            ex_flush_o = 1'b1;
          end else if (ld_use_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_flush_o    = 1'b1;
          end else if (md_req_i) begin
            md_start_o = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          md_busy_o = 1'b1;
          if (branch_taken_i) begin
            md_abort_o = 1'b1;
            if_flush_o = 1'b1;
            id_flush_o = 1'b1;
            ex_flush_o = 1'b1;
          end else begin
            // Freeze IF/ID and feed a bubble into EX while the unit works.
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_flush_o    = 1'b1;
          end
        end
        ST_MD_DONE: begin
          if (branch_taken_i) begin
            if_flush_o = 1'b1;
            id_flush_o = 1'b1;
            ex_flush_o = 1'b1;
          end
        end
        default: begin
          md_busy_o = 1'b0;
        end
      endcase
    end
  end

  assign timeout_o = timeout_q;

  sat_counter #(
    .WIDTH (PERF_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (!pc_write_o),
    .count (stall_cnt_o)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline stall/flush sequencer for the 5-stage pipelined CPU. It sits between the load-use/branch hazard logic, the multi-cycle multiply/divide unit, and the PC / IF_ID / ID_EX / EX_MEM pipeline registers. It merges three stall and flush sources into one prioritised control set, and holds the pipeline for the duration of a multi-cycle mul/div operation. It also aborts a wrong-path mul/div on a taken branch, runs a completion watchdog, and counts stall cycles.

## Interface
- MD_LAT, 8: maximum mul/div latency in cycles; watchdog limit, ≥2.
- CNT_W, 4: width of the mul/div cycle counter; must hold MD_LAT-1.
- PERF_W, 16: width of the stall-cycle performance counter.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ld_use_i  in  1  load-use hazard detected for the instruction in ID.
- branch_taken_i  in  1  PCSrc, a resolved taken branch/jump.
- md_req_i  in  1  instruction in ID is mul/div.
- md_done_i  in  1  mul/div unit result-valid pulse.
- md_start_o  out  1  one-cycle start pulse to the mul/div unit.
- md_abort_o  out  1  one-cycle cancel pulse to the mul/div unit.
- md_busy_o  out  1  state is MD_WAIT.
- pc_write_o  out  1  PC load enable.
- if_id_write_o  out  1  IF_ID load enable.
- if_flush_o, id_flush_o, ex_flush_o  out  1 each  zero the control fields of IF_ID, ID_EX and EX_MEM respectively.
- timeout_o  out  1  sticky; the watchdog expired at least once.
- stall_cnt_o  out  PERF_W  saturating count of cycles with pc_write_o=0.

## Operation
- The FSM has three states: IDLE, MD_WAIT and MD_DONE.
- Default outputs: pc_write_o=1 and if_id_write_o=1. All flush outputs, md_start_o and md_abort_o are 0.
- Priority, highest first: branch_taken_i, then ld_use_i, then md_req_i.

State behaviour:
- **IDLE + branch_taken_i:** if_flush_o, id_flush_o and ex_flush_o are all 1. Writes stay enabled. No start. Stay in IDLE.
- **IDLE + ld_use_i:** pc_write_o=0, if_id_write_o=0, id_flush_o=1. Stay in IDLE. The mul/div start is deferred while a load-use stall is active.
- **IDLE + md_req_i** (no branch, no load-use): md_start_o=1 for this cycle. Counter cleared to 0. Next state MD_WAIT. The pipeline is not stalled in this cycle.
- **MD_WAIT, every cycle:** pc_write_o=0, if_id_write_o=0, id_flush_o=1 (bubble into EX). The counter increments.
  - md_done_i → next state MD_DONE.
  - No done and counter == MD_LAT-1 → set timeout_o, next state MD_DONE.
  - branch_taken_i overrides both of the above: md_abort_o=1, all three flushes=1, writes enabled, next state IDLE.
- **MD_DONE:** writes enabled, no flush, so the mul/div instruction advances into EX. md_req_i is ignored, so the op is not restarted. Next state IDLE.
  - branch_taken_i in MD_DONE: all three flushes=1, next state IDLE.
- **Simultaneous md_done_i and branch_taken_i in MD_WAIT:** the branch wins. md_abort_o=1 and the late result is discarded.
- **md_done_i outside MD_WAIT:** ignored.
- **stall_cnt_o:** increments on each cycle with pc_write_o=0 and saturates at all-ones.
- **timeout_o:** cleared only by reset.

## Timing
- Control outputs are combinational from state and inputs, with zero latency.
- State, counter, timeout_o and stall_cnt_o update on the rising clk_i edge.
- Mul/div stall length: the start cycle, then k MD_WAIT cycles, where done arrives in the k-th MD_WAIT cycle (1 ≤ k ≤ MD_LAT), then one MD_DONE cycle.
- Reset values: state IDLE, counter 0, timeout_o 0, stall_cnt_o 0.
- While rst_i=1, outputs are forced regardless of inputs: pc_write_o=1, if_id_write_o=1, all flushes 0, md_start_o=0, md_abort_o=0, md_busy_o=0.
- Reset asserted in MD_WAIT returns the FSM to IDLE immediately. No abort pulse is issued; the mul/div unit shares rst_i.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state typedef (IDLE, MD_WAIT, MD_DONE);
  - the defaults for MD_LAT, CNT_W and PERF_W.
- Sub-module sat_counter (parameter WIDTH; ports inc, count) implements stall_cnt_o.

## Test plan
- **Load-use:** ld_use_i=1 for 1 cycle in IDLE → pc_write_o=0, if_id_write_o=0, id_flush_o=1 that cycle; stall_cnt_o goes 0→1.
- **Normal mul/div:** md_req_i held, md_done_i on the 3rd MD_WAIT cycle → md_start_o pulses once; md_busy_o=1 for 3 cycles; MD_DONE releases the pipeline; no second md_start_o; stall_cnt_o=3.
- **Timeout:** MD_LAT=8, md_done_i never asserted → exactly 8 MD_WAIT cycles, then timeout_o=1 and stays 1 after further ops.
- **Branch abort:** branch_taken_i in the 2nd MD_WAIT cycle, together with md_done_i → md_abort_o=1, all three flushes=1, state IDLE next cycle, no MD_DONE.
- **Priority:** ld_use_i and md_req_i together → no md_start_o until ld_use_i drops; with branch_taken_i also high → flushes only, no stall.
- **Mid-op reset:** rst_i pulsed mid-cycle in MD_WAIT → outputs at reset values asynchronously; IDLE, counter 0, stall_cnt_o 0.
